prefix_gate_pipe: RTL
=====================

// Module: prefix_gate_pipe
// PURPOSE
//  Parametrised, pipelined successor of the 4-input AND chain: reduces WIDTH lanes
//  with a selectable bitwise op (AND/OR/XOR) and outputs every partial prefix result.
//  Adds registered stages, a valid/ready handshake with back-pressure, and per-op mode.
//  Sits between a producer stream and any consumer needing chained gate results.
// PARAMETERS
//  WIDTH          4   number of input lanes (>=2)
//  LANE_W         1   bit width of each lane (bitwise op per bit)
//  OPS_PER_STAGE  1   chain links evaluated per pipeline stage (>=1)
//  Derived: STAGES = ceil((WIDTH-1)/OPS_PER_STAGE) = latency in cycles
// PORTS
//  clk         in   1                  single clock, rising edge
//  rst         in   1                  synchronous, active-high reset
//  in_valid    in   1                  input beat valid
//  in_ready    out  1                  block accepts beat this cycle
//  in_data     in   WIDTH*LANE_W       lane k at [k*LANE_W +: LANE_W]
//  in_op       in   2                  00 AND, 01 OR, 10 XOR, 11 treated as AND
//  out_valid   out  1                  output beat valid
//  out_ready   in   1                  consumer accepts beat
//  out_prefix  out  (WIDTH-1)*LANE_W   prefix j at [j*LANE_W +: LANE_W]
//  out_all     out  LANE_W             full reduction (= prefix WIDTH-2)
// BEHAVIOUR
//  - Prefix j = lane0 op lane1 op ... op lane(j+1), j=0..WIDTH-2 (WIDTH=4, AND:
//    prefix0=a&b, prefix1=a&b&c, prefix2=a&b&c&d).
//  - Stage s (0..STAGES-1) computes prefixes s*OPS_PER_STAGE .. min((s+1)*OPS_PER_STAGE,
//    WIDTH-1)-1 from the previous stage's last prefix; registers carry valid, op,
//    unconsumed lanes, and prefixes computed so far. in_op travels with its beat.
//  - Global advance: en = out_ready | ~out_valid. in_ready = en. When en=1 every
//    stage register loads from its predecessor (stage 0 from inputs, valid=in_valid
//    & in_ready); when en=0 all stage registers hold. Bubbles are not compressed.
//  - Transfer occurs on in_valid&in_ready (input) / out_valid&out_ready (output).
//  - Latency: beat accepted at cycle t appears at cycle t+STAGES when no stall;
//    each stall cycle adds one. Throughput 1 beat/cycle with out_ready held high.
//  - Outputs hold stable while out_valid=1 and out_ready=0.
//  - in_op=11 produces results identical to in_op=00.
//  - Reset: all stage valids=0; out_valid=0, out_prefix=0, out_all=0; in_ready=1
//    (follows en). Reset mid-stream discards all in-flight beats; no beat emitted
//    from data accepted before or during the reset cycle.
//  - rst has priority over en in the same cycle.
//  - in_data/in_op ignored when in_valid=0; stage data registers may hold stale
//    values but out_prefix/out_all only meaningful when out_valid=1.
// TESTING (WIDTH=4, LANE_W=1, OPS_PER_STAGE=1 unless noted; STAGES=3)
//  1 AND: in_data=4'b1111, op=00 -> 3 cycles later out_prefix=3'b111, out_all=1;
//    in_data=4'b1011 (d=1,c=0,b=1,a=1) -> out_prefix=3'b001, out_all=0.
//  2 OR/XOR: in_data=4'b0100, op=01 -> out_prefix=3'b110; same data op=10 ->
//    out_prefix=3'b110, out_all=1; in_data=4'b1111 op=10 -> out_prefix=3'b010, op=11 -> 3'b111.
//  3 Streaming: 8 back-to-back beats, out_ready=1 -> 8 results in order on
//    consecutive cycles starting 3 cycles after first accept; in_ready stays 1.
//  4 Back-pressure: hold out_ready=0 for 5 cycles with pipe full -> in_ready=0,
//    outputs stable, no loss/duplication; release -> remaining beats in order.
//  5 Reset mid-stream: assert rst with 3 beats in flight -> next cycle out_valid=0,
//    out_*=0; no stale beat ever emitted afterwards.
//  6 Param sweep WIDTH=9, LANE_W=8, OPS_PER_STAGE=3 (STAGES=3): random data/op vs
//    reference model, all 8 prefixes checked, latency exactly 3 with no stall.

Source files
------------

// File: rtl/prefix_gate_pipe.sv
// Pipelined prefix reduction of WIDTH lanes with a per-beat AND/OR/XOR op.
// Global-stall pipeline: every stage advances together when the output slot is free.
module prefix_gate_pipe #(
  parameter int WIDTH         = 4,
  parameter int LANE_W        = 1,
  parameter int OPS_PER_STAGE = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH*LANE_W-1:0]      in_data,
  input  logic [1:0]                   in_op,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [(WIDTH-1)*LANE_W-1:0]  out_prefix,
  output logic [LANE_W-1:0]            out_all
);

  localparam int NP     = WIDTH - 1;
  localparam int STAGES = (NP + OPS_PER_STAGE - 1) / OPS_PER_STAGE;
  localparam int PW     = NP * LANE_W;

  function automatic logic [LANE_W-1:0] gate_op(input logic [1:0] op,
                                                input logic [LANE_W-1:0] a,
                                                input logic [LANE_W-1:0] b);
    case (op)
      2'b01:   gate_op = a | b;
      2'b10:   gate_op = a ^ b;
      default: gate_op = a & b;
    endcase
  endfunction

  logic en;
  assign en       = out_ready | ~out_valid;
  assign in_ready = en;

  genvar s;
  generate
    for (s = 0; s < STAGES; s++) begin : g_st
      localparam int LO    = s * OPS_PER_STAGE;
      localparam int HI    = ((s + 1) * OPS_PER_STAGE < NP) ? (s + 1) * OPS_PER_STAGE : NP;
      localparam int NEW   = HI - LO;
      localparam int BASE  = (s == 0) ? 0 : LO + 1;
      localparam int IN_N  = WIDTH - BASE;
      localparam int OFF   = (s == 0) ? 1 : 0;
      localparam int REM_N = WIDTH - HI - 1;

      logic [IN_N*LANE_W-1:0] lanes_in;
      logic [LANE_W-1:0]      acc_in;
      logic [LANE_W-1:0]      acc;
      logic [1:0]             op_in;
      logic                   vld_in;
      logic [NEW*LANE_W-1:0]  new_d;
      logic [HI*LANE_W-1:0]   pre_d;
      logic [HI*LANE_W-1:0]   pre_q;
      logic                   vld_q;

      // Stage input: raw beat for stage 0, predecessor registers otherwise
      if (s == 0) begin : g_src
        assign lanes_in = in_data;
        assign acc_in   = lanes_in[LANE_W-1:0];
        assign op_in    = in_op;
        assign vld_in   = in_valid;
        assign pre_d    = new_d;
      end else begin : g_src
        assign lanes_in = g_st[s-1].g_keep.rem_q;
        assign acc_in   = g_st[s-1].pre_q[LO*LANE_W-1 -: LANE_W];
        assign op_in    = g_st[s-1].g_keep.op_q;
        assign vld_in   = g_st[s-1].vld_q;
        assign pre_d    = {new_d, g_st[s-1].pre_q};
      end

      always_comb begin
        acc   = acc_in;
        new_d = '0;
        for (int j = 0; j < NEW; j++) begin
          acc = gate_op(op_in, acc, lanes_in[(j + OFF)*LANE_W +: LANE_W]);
          new_d[j*LANE_W +: LANE_W] = acc;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          vld_q <= 1'b0;
        end else if (en) begin
          vld_q <= vld_in;
        end
      end

      // Intermediate stages carry the lanes still to be consumed and the op
      if (REM_N > 0) begin : g_keep
        logic [REM_N*LANE_W-1:0] rem_q;
        logic [1:0]              op_q;

        always_ff @(posedge clk) begin
          if (en) begin
            rem_q <= lanes_in[IN_N*LANE_W-1 -: REM_N*LANE_W];
            op_q  <= op_in;
            pre_q <= pre_d;
          end
        end
      end else begin : g_last
        always_ff @(posedge clk) begin
          if (rst) begin
            pre_q <= '0;
          end else if (en) begin
            pre_q <= pre_d;
          end
        end
      end
    end
  endgenerate

  assign out_valid  = g_st[STAGES-1].vld_q;
  assign out_prefix = g_st[STAGES-1].pre_q;
  assign out_all    = out_prefix[PW-1 -: LANE_W];

endmodule
